// File: rtl/thr_trace_pkg.sv
// -----------------------------------------------------------------------------
// thr_trace_pkg
// Shared types and arithmetic helpers for the adaptive-threshold trace
// generator.
//   state_e  : controller states (CLEAR, IDLE, SWEEP)
//   op_e     : kind of access travelling through the stage-1 pipeline register
//   sat_add  : saturating trace increment
//   decay    : one exponential decay step, guaranteed to make progress to 0
// -----------------------------------------------------------------------------
package thr_trace_pkg;

    // Trace width the helper functions operate on. The top-level T_FIX_WID
    // parameter defaults to this value and is expected to match it.
    localparam int TRACE_WID = 16;

    typedef logic [TRACE_WID-1:0] trace_t;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SWEEP
    } state_e;

    typedef enum logic {
        OP_QUERY,
        OP_DECAY
    } op_e;

    // trace + inc, clamped to the all-ones value instead of wrapping.
    function automatic trace_t sat_add(input trace_t trace, input trace_t inc);
        logic [TRACE_WID:0] sum;
        sum = {1'b0, trace} + {1'b0, inc};
        return sum[TRACE_WID] ? '1 : sum[TRACE_WID-1:0];
    endfunction

    // trace * (1 - 2^-shift). Small non-zero traces would otherwise stick at
    // their value forever once the shifted term truncates to 0, so they lose
    // one LSB per step instead.
    function automatic trace_t decay(input trace_t trace, input int unsigned shift);
        trace_t dec;
        dec = trace >> shift;
        if (dec == '0 && trace != '0) begin
            dec = trace_t'(1);
        end
        return trace - dec;
    endfunction

endpackage

// File: rtl/thr_trace_gen_if.sv
// -----------------------------------------------------------------------------
// thr_trace_gen_if
// Query bus between the neuron-update pipeline (master) and the trace
// generator (slave).
//   n_vld_i     : query valid
//   n_addr_i    : queried neuron index
//   spk_i       : neuron spiked, qualified by n_vld_i
//   ts_efa_o_th : trace of the queried neuron before this query's spike
//   trace_vld_o : ts_efa_o_th valid (one cycle after the query)
// -----------------------------------------------------------------------------
interface thr_trace_gen_if #(
    parameter int NEURON_NO = 2**8,
    parameter int T_FIX_WID = 16
);
    logic                         n_vld_i;
    logic [$clog2(NEURON_NO)-1:0] n_addr_i;
    logic                         spk_i;
    logic [T_FIX_WID-1:0]         ts_efa_o_th;
    logic                         trace_vld_o;

    modport master (
        output n_vld_i, n_addr_i, spk_i,
        input  ts_efa_o_th, trace_vld_o
    );

    modport slave (
        input  n_vld_i, n_addr_i, spk_i,
        output ts_efa_o_th, trace_vld_o
    );
endinterface

// File: rtl/trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
// Simple dual-port RAM holding one trace per neuron.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data, one cycle after raddr
// A same-cycle read and write of one address returns the old contents; the
// caller forwards the new value itself.
// -----------------------------------------------------------------------------
module trace_ram #(
    parameter int DEPTH = 256,
    parameter int WID   = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WID-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WID-1:0]           rdata
);
    // NOTE: the array has no reset so it maps onto block RAM; the owner
    // initialises it by sweeping zeros through the write port instead.
    logic [WID-1:0] mem [DEPTH];

    // NOTE: clocked state is always assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/thr_trace_gen.sv
// -----------------------------------------------------------------------------
// thr_trace_gen
// Per-neuron adaptive-threshold trace generator. Queries return a neuron's
// trace one cycle later and optionally bump it by SPK_INC (saturating); a
// background sweep launched by ts_tick decays every trace once per timestep.
//   clk          : clock
//   reset        : synchronous, active-high
//   ts_tick      : timestep pulse, launches the decay sweep from IDLE
//   q            : query bus (thr_trace_gen_if.slave)
//   busy_o       : CLEAR or SWEEP in progress
//   sweep_done_o : one-cycle pulse during the last decay write
//   overrun_o    : sticky, ts_tick seen outside IDLE
// Pipeline: stage 0 issues the RAM read (query has priority over the sweep),
// stage 1 receives the data, produces the outputs and does the write-back.
// -----------------------------------------------------------------------------
module thr_trace_gen
    import thr_trace_pkg::*;
#(
    parameter int                   NEURON_NO   = 2**8,
    parameter int                   T_FIX_WID   = TRACE_WID,
    parameter int                   DECAY_SHIFT = 4,
    parameter logic [T_FIX_WID-1:0] SPK_INC     = 16'h1000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ts_tick,
    thr_trace_gen_if.slave q,
    output logic           busy_o,
    output logic           sweep_done_o,
    output logic           overrun_o
);
    localparam int            AW        = $clog2(NEURON_NO);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NEURON_NO - 1);

    state_e state, state_nxt;

    // One spare MSB marks "every sweep read issued" while the last write is
    // still in flight, so SWEEP lasts until that write lands.
    logic [AW:0] sweep_addr;

    // Stage 0
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    op_e           rd_kind;
    logic          sweep_issue;
    logic          fwd_hit;

    // Stage 1
    logic                 s1_vld;
    op_e                  s1_kind;
    logic                 s1_spk;
    logic [AW-1:0]        s1_addr;
    logic                 s1_fwd;
    logic [T_FIX_WID-1:0] s1_fwd_data;
    logic [T_FIX_WID-1:0] ram_rdata;
    logic [T_FIX_WID-1:0] cur;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [T_FIX_WID-1:0] wr_data;

    // Outputs
    logic                 trace_vld_q;
    logic [T_FIX_WID-1:0] hold_q;
    logic                 sweep_done_q;
    logic                 overrun_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: if (sweep_addr[AW-1:0] == LAST_ADDR) state_nxt = IDLE;
            IDLE:  if (ts_tick)                         state_nxt = SWEEP;
            SWEEP: if (sweep_done_q)                    state_nxt = IDLE;
            default:                                    state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
    end

    // Shared address counter: zero-fill in CLEAR, decay pointer in SWEEP.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_addr <= '0;
        end else begin
            unique case (state)
                CLEAR:   sweep_addr <= (sweep_addr[AW-1:0] == LAST_ADDR) ? '0 : sweep_addr + 1'b1;
                SWEEP:   if (sweep_issue) sweep_addr <= sweep_addr + 1'b1;
                default: sweep_addr <= '0;
            endcase
        end
    end

    // ---------------- Stage 0: read issue ----------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_en       = 1'b0;
        rd_addr     = sweep_addr[AW-1:0];
        rd_kind     = OP_DECAY;
        sweep_issue = 1'b0;
        if (state != CLEAR) begin
            if (q.n_vld_i) begin
                rd_en   = 1'b1;
                rd_addr = q.n_addr_i;
                rd_kind = OP_QUERY;
            end else if (state == SWEEP && !sweep_addr[AW]) begin
                rd_en       = 1'b1;
                sweep_issue = 1'b1;
            end
        end
    end

    // The RAM returns pre-write data on a same-address collision, so the
    // value being written now is captured for the new read instead.
    assign fwd_hit = rd_en && wr_en && (rd_addr == wr_addr);

    // ---------------- Stage 1: data, write-back ----------------
    assign cur = s1_fwd ? s1_fwd_data : ram_rdata;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_addr;
        wr_data = '0;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = sweep_addr[AW-1:0];
        end else if (s1_vld) begin
            if (s1_kind == OP_DECAY) begin
                wr_en   = 1'b1;
                wr_data = T_FIX_WID'(decay(trace_t'(cur), DECAY_SHIFT));
            end else if (s1_spk) begin
                wr_en   = 1'b1;
                wr_data = T_FIX_WID'(sat_add(trace_t'(cur), trace_t'(SPK_INC)));
            end
        end
    end

    trace_ram #(
        .DEPTH (NEURON_NO),
        .WID   (T_FIX_WID)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en && !reset),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld       <= 1'b0;
            s1_kind      <= OP_QUERY;
            s1_spk       <= 1'b0;
            s1_addr      <= '0;
            s1_fwd       <= 1'b0;
            s1_fwd_data  <= '0;
            trace_vld_q  <= 1'b0;
            hold_q       <= '0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            s1_vld       <= rd_en;
            s1_kind      <= rd_kind;
            s1_spk       <= q.spk_i;
            s1_addr      <= rd_addr;
            s1_fwd       <= fwd_hit;
            s1_fwd_data  <= wr_data;
            trace_vld_q  <= rd_en && (rd_kind == OP_QUERY);
            sweep_done_q <= sweep_issue && (sweep_addr[AW-1:0] == LAST_ADDR);
            if (trace_vld_q) begin
                hold_q <= cur;
            end
            if (ts_tick && state != IDLE) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // The RAM output register is the query output register; hold_q keeps the
    // last query result visible while sweep reads move the RAM output.
    assign q.trace_vld_o = trace_vld_q;
    assign q.ts_efa_o_th = trace_vld_q ? cur : hold_q;
    assign sweep_done_o  = sweep_done_q;
    assign overrun_o     = overrun_q;

endmodule
